orb_descriptor_controller: RTL

Sequencing controller for the 37×37 ORB patch window. It streams pixel columns into the window and detects keypoint requests. For each keypoint it freezes the window, quantises the patch orientation from the window's intensity moments, and walks a 256-pair steered sampling pattern through the window's random-access read ports. It assembles the 256-bit binary descriptor and sits between the column/keypoint source and the descriptor output FIFO.

---
 rtl/orb_descriptor_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/orb_descriptor_controller.sv
// ORB descriptor sequencer for a 37x37 patch window.
// Streams columns into the window and, for each keypoint, freezes the window,
// quantises the orientation and walks the steered pair pattern into a descriptor.
// Ports: clk/reset_n; in_pix_valid/out_pix_ready column handshake; in_kp_flag,
// in_flush_req; out_win_* window control/coords; in_win_* window data/moments;
// out_pat_addr/in_pat_coord* pattern ROM; out_desc* descriptor to FIFO with
// in_desc_ready.
module orb_descriptor_controller #(
    parameter int LUMA_BITS   = 8,
    parameter int COORD_BITS  = 6,
    parameter int MOMENT_BITS = 24,
    parameter int NUM_PAIRS   = 256,
    parameter int PAIR_BITS   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_pix_valid,
    output logic                          out_pix_ready,
    input  logic                          in_kp_flag,
    input  logic                          in_flush_req,
    output logic                          out_win_valid,
    output logic                          out_win_flush,
    output logic                          out_win_mode,
    output logic [2*COORD_BITS-1:0]       out_win_coord1,
    output logic [2*COORD_BITS-1:0]       out_win_coord2,
    input  logic                          in_win_patch_valid,
    input  logic [LUMA_BITS-1:0]          in_win_pix1,
    input  logic [LUMA_BITS-1:0]          in_win_pix2,
    input  logic signed [MOMENT_BITS-1:0] in_win_xmoment,
    input  logic signed [MOMENT_BITS-1:0] in_win_ymoment,
    output logic [3+PAIR_BITS:0]          out_pat_addr,
    input  logic [2*COORD_BITS-1:0]       in_pat_coord1,
    input  logic [2*COORD_BITS-1:0]       in_pat_coord2,
    output logic [NUM_PAIRS-1:0]          out_desc,
    output logic [3:0]                    out_desc_bin,
    output logic                          out_desc_valid,
    input  logic                          in_desc_ready
);

    localparam int AW       = MOMENT_BITS + 10;
    localparam int WIN_COLS = 37;

    typedef enum logic [2:0] {
        FLUSH, FILL, STREAM, ANGLE, SAMPLE, DRAIN, OUTPUT
    } state_t;

    state_t state, state_nx;

    logic signed [MOMENT_BITS-1:0] xm_q, ym_q;
    logic [3:0]           bin_q, bin_c;
    logic [3+PAIR_BITS:0] addr_q;
    logic [NUM_PAIRS-1:0] desc_q;
    logic                 v1_q, v2_q;
    logic                 drain_q, flush_q, mode_q, valid_q;
    logic                 hold_q;
    logic [5:0]           col_q;
    logic                 pix_ready, kp_take, last_pair;

    assign last_pair = &addr_q[PAIR_BITS-1:0];

    always_comb begin
        state_nx  = state;
        pix_ready = 1'b0;
        kp_take   = 1'b0;
        unique case (state)
            FLUSH:  if (flush_q) state_nx = FILL;
            FILL: begin
                pix_ready = 1'b1;
                if (in_win_patch_valid) state_nx = STREAM;
            end
            STREAM: begin
                // hold_q keeps a stale patch from re-triggering after a descriptor
                kp_take   = in_win_patch_valid & in_kp_flag & ~hold_q;
                pix_ready = ~kp_take;
                if (kp_take) state_nx = ANGLE;
            end
            ANGLE:  state_nx = SAMPLE;
            SAMPLE: if (last_pair) state_nx = DRAIN;
            DRAIN:  if (drain_q) state_nx = OUTPUT;
            OUTPUT: if (in_desc_ready) state_nx = STREAM;
            default: state_nx = FLUSH;
        endcase
        if (in_flush_req) state_nx = FLUSH;
    end

    // Orientation: sector thresholds are 64*tan(11.25/33.75/56.25/78.75 deg)
    logic                   x_neg, y_neg;
    logic [MOMENT_BITS-1:0] xmag, ymag;
    logic [AW-1:0]          ax, ay, ay64;
    logic [3:0]             s;

    always_comb begin
        x_neg = xm_q[MOMENT_BITS-1];
        y_neg = ym_q[MOMENT_BITS-1];
        xmag  = x_neg ? (~xm_q + 1'b1) : xm_q;
        ymag  = y_neg ? (~ym_q + 1'b1) : ym_q;
        ax    = {{10{1'b0}}, xmag};
        ay    = {{10{1'b0}}, ymag};
        ay64  = ay << 6;
        s     = {3'b0, ay64 > ax * AW'(13)}
              + {3'b0, ay64 > ax * AW'(43)}
              + {3'b0, ay64 > ax * AW'(96)}
              + {3'b0, ay64 > ax * AW'(322)};
        bin_c = s;
        unique case ({x_neg, y_neg})
            2'b00: bin_c = s;
            2'b10: bin_c = 4'd8 - s;
            2'b11: bin_c = 4'd8 + s;
            2'b01: bin_c = 4'd0 - s;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FLUSH;
            flush_q <= 1'b0;
            mode_q  <= 1'b1;
            valid_q <= 1'b0;
            xm_q    <= '0;
            ym_q    <= '0;
            bin_q   <= '0;
            addr_q  <= '0;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            desc_q  <= '0;
            hold_q  <= 1'b0;
            col_q   <= '0;
        end else begin
            state   <= state_nx;
            flush_q <= (state_nx == FLUSH);
            mode_q  <= (state_nx == FLUSH) || (state_nx == FILL) ||
                       (state_nx == STREAM);
            valid_q <= (state_nx == OUTPUT);
            drain_q <= (state == DRAIN) & ~drain_q;

            if (kp_take) begin
                xm_q <= in_win_xmoment;
                ym_q <= in_win_ymoment;
            end

            if (state == ANGLE) begin
                bin_q  <= bin_c;
                addr_q <= {bin_c, {PAIR_BITS{1'b0}}};
            end else if (state == SAMPLE) begin
                addr_q[PAIR_BITS-1:0] <= addr_q[PAIR_BITS-1:0] + 1'b1;
            end

            // v1: ROM data on coords, v2: window pixels present
            if (in_flush_req) begin
                v1_q   <= 1'b0;
                v2_q   <= 1'b0;
                desc_q <= '0;
            end else begin
                v1_q <= (state == SAMPLE);
                v2_q <= v1_q;
                if (v2_q)
                    desc_q <= {in_win_pix1 < in_win_pix2,
                               desc_q[NUM_PAIRS-1:1]};
            end

            if (state == OUTPUT && state_nx == STREAM) begin
                hold_q <= 1'b1;
                col_q  <= '0;
            end else if (state_nx == FLUSH) begin
                hold_q <= 1'b0;
            end else if (hold_q && out_win_valid) begin
                if (col_q == 6'(WIN_COLS - 1)) hold_q <= 1'b0;
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign out_pix_ready  = pix_ready;
    assign out_win_valid  = pix_ready & in_pix_valid;
    assign out_win_flush  = flush_q;
    assign out_win_mode   = mode_q;
    assign out_win_coord1 = in_pat_coord1;
    assign out_win_coord2 = in_pat_coord2;
    assign out_pat_addr   = addr_q;
    assign out_desc       = desc_q;
    assign out_desc_bin   = bin_q;
    assign out_desc_valid = valid_q;

endmodule
